// File: rtl/check_summary_pkg.sv
// Shared encodings for the line-check statistics block: record tags, error bit
// positions, counter select codes and the control state enumeration.
package check_summary_pkg;

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;
  localparam logic [1:0] FMT_BAD  = 2'b11;

  // error_code is {grf, addr, pc, time}
  localparam int ERR_TIME = 0;
  localparam int ERR_PC   = 1;
  localparam int ERR_ADDR = 2;
  localparam int ERR_GRF  = 3;

  localparam int SEL_REG   = 0;
  localparam int SEL_MEM   = 1;
  localparam int SEL_ERR   = 2;
  localparam int SEL_TIME  = 3;
  localparam int SEL_PC    = 4;
  localparam int SEL_ADDR  = 5;
  localparam int SEL_GRF   = 6;
  localparam int SEL_TOTAL = 7;
  localparam int NUM_CNT   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_ERR   = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  function automatic logic is_record(input logic [1:0] fmt);
    return (fmt == FMT_REG) || (fmt == FMT_MEM);
  endfunction

endpackage

// File: rtl/check_summary_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  logic [CNT_W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {CNT_W{1'b1}})) begin
      q_d = q_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/check_summary.sv
// Statistics collector for line-checker records: per-kind counters, first-error
// capture and a sticky alarm on a run of consecutive erroneous records.
module check_summary
  import check_summary_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int STREAK_TH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [1:0]       format_type,
  input  logic [3:0]       error_code,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             first_err_valid,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [3:0]       first_err_code,
  output logic             alarm
);

  localparam logic [3:0] STREAK_TH_L = 4'(STREAK_TH);

  logic             is_rec;
  logic             has_err;
  logic [NUM_CNT-1:0] inc_vec;
  logic [CNT_W-1:0] cnt [NUM_CNT];

  logic [CNT_W-1:0] rd_data_q;
  state_e           state_q;
  logic [3:0]       streak_q, streak_d;
  logic             first_err_valid_q;
  logic [CNT_W-1:0] first_err_idx_q;
  logic [3:0]       first_err_code_q;
  logic             alarm_q;

  assign is_rec  = is_record(format_type);
  assign has_err = is_rec && (error_code != 4'b0000);

  always_comb begin
    inc_vec            = '0;
    inc_vec[SEL_REG]   = is_rec && (format_type == FMT_REG);
    inc_vec[SEL_MEM]   = is_rec && (format_type == FMT_MEM);
    inc_vec[SEL_ERR]   = has_err;
    inc_vec[SEL_TIME]  = has_err && error_code[ERR_TIME];
    inc_vec[SEL_PC]    = has_err && error_code[ERR_PC];
    inc_vec[SEL_ADDR]  = has_err && error_code[ERR_ADDR];
    inc_vec[SEL_GRF]   = has_err && error_code[ERR_GRF];
    inc_vec[SEL_TOTAL] = is_rec;
  end

  // clear outranks inc inside each counter, so a coincident record is dropped
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
      sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (inc_vec[gi]),
        .q     (cnt[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= cnt[rd_sel];
    end
  end

  always_comb begin
    streak_d = streak_q;
    if (has_err) begin
      streak_d = (streak_q == 4'hF) ? streak_q : streak_q + 4'd1;
    end else if (is_rec) begin
      streak_d = 4'd0;
    end
  end

  // The total counter still holds its pre-increment value here, which is the record index.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q           <= ST_IDLE;
      streak_q          <= 4'd0;
      first_err_valid_q <= 1'b0;
      first_err_idx_q   <= '0;
      first_err_code_q  <= 4'd0;
      alarm_q           <= 1'b0;
    end else begin
      streak_q <= streak_d;
      if (is_rec) begin
        case (state_q)
          ST_IDLE, ST_RUN: begin
            if (has_err) begin
              first_err_valid_q <= 1'b1;
              first_err_idx_q   <= cnt[SEL_TOTAL];
              first_err_code_q  <= error_code;
              if (streak_d == STREAK_TH_L) begin
                state_q <= ST_ALARM;
                alarm_q <= 1'b1;
              end else begin
                state_q <= ST_ERR;
              end
            end else begin
              state_q <= ST_RUN;
            end
          end
          ST_ERR: begin
            if (has_err && (streak_d == STREAK_TH_L)) begin
              state_q <= ST_ALARM;
              alarm_q <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_ALARM;
          end
        endcase
      end
    end
  end

  assign rd_data         = rd_data_q;
  assign first_err_valid = first_err_valid_q;
  assign first_err_idx   = first_err_idx_q;
  assign first_err_code  = first_err_code_q;
  assign alarm           = alarm_q;

endmodule

// File: doc/check_summary.md
CHECK_SUMMARY -- requirements
Module: check_summary

Interface
REQ-001 SHALL have parameter CNT_W, default 16, counter width in bits (8..32).
REQ-002 SHALL have parameter STREAK_TH, default 3, consecutive-error count that raises alarm (1..15).
REQ-003 SHALL have clk  input  1  clock; all state changes on posedge clk.
REQ-004 SHALL have reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have clear  input  1  synchronous statistics clear, active-high.
REQ-006 SHALL have format_type  input  2  per-cycle record tag from line checker: 00 none, 01 register-write line, 10 memory-write line, 11 illegal.
REQ-007 SHALL have error_code  input  4  {grf, addr, pc, time} error flags, meaningful only when format_type is 01 or 10.
REQ-008 SHALL have rd_sel  input  3  counter select: 0 reg lines, 1 mem lines, 2 error lines, 3 time err, 4 pc err, 5 addr err, 6 grf err, 7 total records.
REQ-009 SHALL have rd_data  output  CNT_W  selected counter value, registered.
REQ-010 SHALL have first_err_valid  output  1  a record with nonzero error_code has been seen since reset/clear.
REQ-011 SHALL have first_err_idx  output  CNT_W  record index (0-based) of the first erroneous record.
REQ-012 SHALL have first_err_code  output  4  error_code of the first erroneous record.
REQ-013 SHALL have alarm  output  1  sticky flag: STREAK_TH consecutive erroneous records seen.

Function
REQ-014 A cycle SHALL be a record iff format_type is 01 or 10; 00 and 11 SHALL change no state.
REQ-015 On a record, total SHALL increment; reg or mem counter SHALL increment per format_type.
REQ-016 On a record with error_code != 0, error-line counter SHALL increment once, and each set bit SHALL increment its own per-bit counter in the same cycle.
REQ-017 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-018 Record index SHALL be the total value before that record's increment; saturation of total SHALL freeze the index at max.
REQ-019 Control SHALL be a state machine IDLE -> RUN (first record, no error) -> ERR (first erroneous record) -> ALARM (streak reaches STREAK_TH); IDLE may go directly to ERR; ERR/ALARM never revert except on clear/reset.
REQ-020 On entry to ERR, first_err_idx and first_err_code SHALL be latched and held; later errors SHALL not overwrite them.
REQ-021 Streak counter (4 bits) SHALL increment on erroneous records (saturating at 15), zero on error-free records, unaffected by non-record cycles.
REQ-022 alarm SHALL assert the cycle after the record that makes streak equal STREAK_TH, and stay high in ALARM regardless of later clean records.
REQ-023 rd_data SHALL present counter[rd_sel] one cycle after rd_sel, reflecting counter values as updated on that same edge's previous state (value before the concurrent record).
REQ-024 clear SHALL zero all counters, streak, first_err_*, alarm and return to IDLE; a record coincident with clear SHALL be discarded.
REQ-025 first_err_valid SHALL equal (state is ERR or ALARM).

Reset
REQ-026 On reset: state IDLE, all counters, streak, rd_data, first_err_idx, first_err_code 0, first_err_valid 0, alarm 0.
REQ-027 reset SHALL take priority over clear and any record in the same cycle; reset mid-stream SHALL discard all history.

Structure
REQ-028 Shared package SHALL hold format_type encodings (FMT_NONE, FMT_REG, FMT_MEM, FMT_BAD), error bit positions, rd_sel codes and the state enumeration.
REQ-029 One sub-module sat_counter (CNT_W, inc, clr -> q) SHALL be instantiated eight times.

Verification
REQ-030 Reset, then format 01 err 0000 x3 and 10 err 0000 x2 -> rd_sel 0 gives 3, 1 gives 2, 7 gives 5, alarm 0, first_err_valid 0.
REQ-031 Records: 01/0000, 10/0000, 01/1010 -> first_err_idx 2, first_err_code 1010, counters grf 1, pc 1, error lines 1.
REQ-032 STREAK_TH 3: errors, errors, clean, errors, errors, errors -> alarm high only after sixth record; later clean record keeps alarm 1.
REQ-033 format 11 with error 1111 and format 00 cycles interleaved -> no counter or streak change.
REQ-034 CNT_W 8: 260 clean 01 records -> reg and total read 255; first error after that reports idx 255.
REQ-035 clear coincident with 10/0001 record -> all counters 0, IDLE, first_err_valid 0; next record gets idx 0.
